// File: rtl/demux6to12.sv
// demux6to12: narrow-to-wide pair assembler, the reverse of the 12-to-6 mux datapath.
//
// Collects W-bit beats from a valid/ready stream. Alternate beats are steered into the A and B
// halves of a 2*W pair register. Each completed pair is offered downstream on a second
// valid/ready handshake. A pair accept and a new first beat can occur on the same edge, so the
// block sustains one pair every two cycles with no bubble.
//
// Parameters:
//   W        beat width; the pair is presented as out_b/out_a, W bits each
//   A_FIRST  1: first beat of a pair lands in out_a; 0: first beat lands in out_b
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset_n    asynchronous active-low reset
//   sync       synchronous abort of a partial pair, realigning to the first-beat slot
//   in_valid   in_data holds a beat
//   in_ready   block accepts a beat this cycle (never depends on in_valid)
//   in_data    beat payload
//   out_valid  out_a/out_b hold a complete pair
//   out_ready  downstream takes the pair this cycle
//   out_a      A half of the pair
//   out_b      B half of the pair
//   phase      0 = expecting first beat, 1 = expecting second beat
module demux6to12 #(
  parameter int unsigned W       = 6,
  parameter bit          A_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sync,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         phase
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   out_a_q, out_a_d;
  logic [W-1:0]   out_b_q, out_b_d;

  logic           beat_acc;
  logic           pair_acc;
  logic           write_first;
  logic           write_second;

  // Outputs are decoded straight from the state register, so they are glitch-free and held
  // stable for as long as the state holds.
  assign out_valid = (state_q == StFull);
  assign phase     = (state_q == StHalf);
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;

  // In FULL a beat can only enter when the held pair leaves on the same edge. sync blocks the
  // beat path in every state: in HALF the offered beat is dropped along with the partial pair.
  assign in_ready = ~sync & ((state_q != StFull) | out_ready);

  assign beat_acc = in_valid & in_ready;
  assign pair_acc = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    write_first  = 1'b0;
    write_second = 1'b0;

    unique case (state_q)
      StEmpty: begin
        if (beat_acc) begin
          write_first = 1'b1;
          state_d     = StHalf;
        end
      end
      StHalf: begin
        if (sync) begin
          // Partial beat is abandoned; data registers keep their contents.
          state_d = StEmpty;
        end else if (beat_acc) begin
          write_second = 1'b1;
          state_d      = StFull;
        end
      end
      StFull: begin
        if (pair_acc) begin
          if (beat_acc) begin
            // Back-to-back: the new first beat replaces the slot of the pair just consumed.
            write_first = 1'b1;
            state_d     = StHalf;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Map first/second slot onto the A/B registers.
  always_comb begin
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    if (write_first) begin
      if (A_FIRST) out_a_d = in_data;
      else         out_b_d = in_data;
    end
    if (write_second) begin
      if (A_FIRST) out_b_d = in_data;
      else         out_a_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      state_q <= state_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

endmodule

// File: tb/tb_demux6to12.sv
// Self-checking bench for demux6to12. A cycle model predicts handshake/phase behaviour and
// pushes each completed pair into a scoreboard queue; the monitor compares and pops pairs as
// the DUT presents and hands them off. A second instance covers A_FIRST=0.
module tb_demux6to12;

  localparam int unsigned W = 6;

  logic         clk;
  logic         reset_n;
  logic         sync;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         phase;

  // A_FIRST = 0 instance
  logic         b_in_valid;
  logic         b_in_ready;
  logic [W-1:0] b_in_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [W-1:0] b_out_a;
  logic [W-1:0] b_out_b;
  logic         b_phase;

  int checks = 0;
  int errors = 0;

  // Model state: 0 empty, 1 half, 2 full
  int           m_state;
  logic [W-1:0] m_first;
  logic [2*W-1:0] sb_q[$];

  demux6to12 #(.W(W), .A_FIRST(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sync     (sync),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .phase    (phase)
  );

  demux6to12 #(.W(W), .A_FIRST(1'b0)) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .sync     (1'b0),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_a    (b_out_a),
    .out_b    (b_out_b),
    .phase    (b_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance the model to the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic s, input logic ordy);
    logic exp_rdy;
    logic bacc;
    logic pacc;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    sync      = s;
    out_ready = ordy;
    #1;
    exp_rdy = !s && (m_state != 2 || ordy);
    bacc    = v && exp_rdy;
    pacc    = (m_state == 2) && ordy;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(m_state == 2));
    check_eq("phase", 32'(phase), 32'(m_state == 1));
    if (m_state == 1) check_eq("half_first", 32'(out_a), 32'(m_first));
    // Monitor: compare the presented pair, pop it when downstream takes it.
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        check_eq("pair", 32'({out_b, out_a}), 32'(sb_q[0]));
        if (ordy) void'(sb_q.pop_front());
      end
    end
    case (m_state)
      0: if (bacc) begin m_first = d; m_state = 1; end
      1: begin
        if (s) m_state = 0;
        else if (bacc) begin sb_q.push_back({d, m_first}); m_state = 2; end
      end
      default: begin
        if (pacc) begin
          if (bacc) begin m_first = d; m_state = 1; end
          else m_state = 0;
        end
      end
    endcase
  endtask

  initial begin
    reset_n     = 1'b0;
    sync        = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b0;
    m_state     = 0;
    m_first     = '0;

    // Reset values
    #12;
    check_eq("rst_out_a", 32'(out_a), 32'd0);
    check_eq("rst_out_b", 32'(out_b), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic pair, phase 0,1,0
    step(1'b1, 6'h15, 1'b0, 1'b1);
    step(1'b1, 6'h2A, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1);

    // Backpressure: pair held for 5 cycles, then consumed with 0x3F captured the same edge
    step(1'b1, 6'h15, 1'b0, 1'b0);
    step(1'b1, 6'h2A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 6'h3F, 1'b0, 1'b0);
    step(1'b1, 6'h3F, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b1, 1'b1);

    // Zero-bubble stream of 8 beats
    for (int i = 1; i <= 8; i++) step(1'b1, 6'(i), 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1);
    check_eq("stream_drained", 32'(sb_q.size()), 32'd0);

    // sync in HALF drops the partial beat and ignores the offered one
    step(1'b1, 6'h11, 1'b0, 1'b1);
    step(1'b1, 6'h22, 1'b1, 1'b1);
    step(1'b1, 6'h33, 1'b0, 1'b1);
    step(1'b1, 6'h0C, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1);

    // sync in EMPTY and FULL: beat path blocked, held pair still drains
    step(1'b1, 6'h01, 1'b1, 1'b1);
    step(1'b1, 6'h09, 1'b0, 1'b0);
    step(1'b1, 6'h12, 1'b0, 1'b0);
    step(1'b1, 6'h24, 1'b1, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1);

    // Asynchronous reset in HALF
    step(1'b1, 6'h3C, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_out_a", 32'(out_a), 32'd0);
    check_eq("arst_out_b", 32'(out_b), 32'd0);
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_phase", 32'(phase), 32'd0);
    m_state = 0;
    m_first = '0;
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 6'h05, 1'b0, 1'b1);
    step(1'b1, 6'h0A, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1);
    check_eq("final_drained", 32'(sb_q.size()), 32'd0);

    // A_FIRST = 0: first beat goes to out_b
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_data  = 6'h07;
    #1;
    check_eq("b_in_ready", 32'(b_in_ready), 32'd1);
    @(negedge clk);
    b_in_data = 6'h38;
    #1;
    check_eq("b_phase", 32'(b_phase), 32'd1);
    check_eq("b_half_b", 32'(b_out_b), 32'h07);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    check_eq("b_out_valid", 32'(b_out_valid), 32'd1);
    check_eq("b_out_b", 32'(b_out_b), 32'h07);
    check_eq("b_out_a", 32'(b_out_a), 32'h38);
    check_eq("b_in_ready_full", 32'(b_in_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
